crc16_sd_line: RTL and testbench



---
 rtl/crc16_sd_line.sv | 41 ++++
 tb/tb_crc16_sd_line.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/crc16_sd_line.sv
// Serial CRC-16/XMODEM (poly 0x1021, init 0) for one SD data line.
// Accumulates one bit per clock, or shifts the CRC out MSB first when unloading.
module crc16_sd_line (
  input  logic iclk,
  input  logic irst,
  input  logic idata,
  input  logic iunload,
  output logic ocrc
);

  localparam logic [15:0] POLY = 16'h1021;

  logic [15:0] r_crc;
  logic        w_fb;
  logic [15:0] w_shift;
  logic [15:0] w_next;

  // Next-state: plain shift when unloading, LFSR step with feedback otherwise
  always_comb begin
    w_fb    = idata ^ r_crc[15];
    w_shift = {r_crc[14:0], 1'b0};
    if (iunload) begin
      w_next = w_shift;
    end else begin
      w_next = w_shift ^ (w_fb ? POLY : 16'h0000);
    end
  end

  // CRC register; async reset also serves as the between-block clear
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_crc <= 16'h0000;
    end else begin
      r_crc <= w_next;
    end
  end

  // MSB is visible in the same cycle unloading starts, so no output stage
  assign ocrc = r_crc[15];

endmodule

// File: tb/tb_crc16_sd_line.sv
// Directed self-checking bench for crc16_sd_line.
module tb_crc16_sd_line;

  logic iclk;
  logic irst;
  logic idata;
  logic iunload;
  logic ocrc;

  int n_total;
  int n_bad;

  crc16_sd_line dut (
    .iclk    (iclk),
    .irst    (irst),
    .idata   (idata),
    .iunload (iunload),
    .ocrc    (ocrc)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] s;
    s = {c[14:0], 1'b0};
    if (b ^ c[15]) s = s ^ 16'h1021;
    return s;
  endfunction

  task automatic do_reset();
    @(negedge iclk);
    irst    = 1'b1;
    iunload = 1'b0;
    idata   = 1'b0;
    @(negedge iclk);
    irst = 1'b0;
  endtask

  task automatic acc_bit(input logic b);
    @(negedge iclk);
    iunload = 1'b0;
    idata   = b;
  endtask

  task automatic acc_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) acc_bit(v[i]);
  endtask

  // Shift out n bits, sampling ocrc before each rising edge
  task automatic unload_n(input int n, output logic [31:0] w);
    w = 32'h0000_0000;
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      iunload = 1'b1;
      idata   = $urandom_range(1, 0);
      #1;
      w = {w[30:0], ocrc};
    end
  endtask

  logic [31:0] w;
  logic [7:0]  msg [9];
  logic [15:0] model;
  logic        b;

  initial begin
    n_total = 0;
    n_bad   = 0;
    irst    = 1'b1;
    idata   = 1'b0;
    iunload = 1'b0;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    #12;
    chk("reset_ocrc", {31'd0, ocrc}, 32'd0);

    // Single '1' gives the polynomial itself
    do_reset();
    acc_bit(1'b1);
    unload_n(16, w);
    chk("single_bit", w, 32'h0000_1021);

    // 1,0,0,0 -> 0x8108 (MSB set), then async reset between edges
    do_reset();
    acc_bit(1'b1); acc_bit(1'b0); acc_bit(1'b0); acc_bit(1'b0);
    @(negedge iclk);
    idata = 1'b1;
    #1;
    chk("pre_rst_msb", {31'd0, ocrc}, 32'd1);
    #1;
    irst = 1'b1;
    #1;
    chk("async_rst_ocrc", {31'd0, ocrc}, 32'd0);
    @(negedge iclk);
    irst  = 1'b0;
    idata = 1'b0;
    unload_n(16, w);
    chk("post_rst_unload", w, 32'h0000_0000);

    // "123456789" check value, then over-unload by 4
    do_reset();
    for (int i = 0; i < 9; i++) acc_byte(msg[i]);
    unload_n(20, w);
    chk("std_vector", {16'd0, w[19:4]}, 32'h0000_31C3);
    for (int i = 0; i < 4; i++) chk("over_unload_zero", {31'd0, w[3 - i]}, 32'd0);
    acc_bit(1'b1);
    unload_n(16, w);
    chk("after_over_unload", w, 32'h0000_1021);

    // 4096 ones
    do_reset();
    for (int i = 0; i < 4096; i++) acc_bit(1'b1);
    unload_n(16, w);
    chk("sd_ones_4096", w, 32'h0000_7FA1);

    // Partial unload then resume accumulate: 0x1021 -> 4 shifts 0x0210 -> '0' 0x0420
    do_reset();
    acc_bit(1'b1);
    unload_n(4, w);
    chk("partial_unload_bits", w, 32'h0000_0001);
    acc_bit(1'b0);
    unload_n(16, w);
    chk("resume_no_clear", w, 32'h0000_0420);

    // Reset in the middle of an unload discards the remainder
    do_reset();
    acc_byte(8'hA5);
    unload_n(5, w);
    do_reset();
    unload_n(16, w);
    chk("mid_unload_rst", w, 32'h0000_0000);

    // Random block followed by its own CRC leaves zero residue
    do_reset();
    model = 16'h0000;
    for (int i = 0; i < 1024; i++) begin
      b = 1'($urandom_range(1, 0));
      model = crc_step(model, b);
      acc_bit(b);
    end
    @(negedge iclk);
    iunload = 1'b0;
    idata   = model[15];
    #1;
    chk("rand_msb", {31'd0, ocrc}, {31'd0, model[15]});
    for (int i = 14; i >= 0; i--) acc_bit(model[i]);
    unload_n(16, w);
    chk("self_check_zero", w, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
